// File: rtl/sum4_pkg.sv
// Shared types and constants for the sum4_sched sequencing controller.
package sum4_pkg;

  typedef enum logic [2:0] {
    IDLE,
    AB,
    C,
    D,
    HOLD
  } state_e;

  localparam int NUM_REQ = 2;

  // Field index inside a packed {d,c,b,a} operand word; the LSB is index*W.
  localparam int OP_A = 0;
  localparam int OP_B = 1;
  localparam int OP_C = 2;
  localparam int OP_D = 3;

  function automatic int field_lsb(input int field, input int w);
    return field * w;
  endfunction

endpackage

// File: rtl/sum4_datapath.sv
// Shared accumulate datapath: one adder whose operands are steered by the
// current phase (AB: a+b, C: acc+c, D: acc+d).
module sum4_datapath
  import sum4_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic [W-1:0] op_c,
  input  logic [W-1:0] op_d,
  input  logic [W+1:0] acc,
  input  logic [2:0]   phase,
  input  logic         load,
  output logic [W+1:0] sum,
  output logic [W+1:0] acc_next
);

  logic [W+1:0] lhs;
  logic [W+1:0] rhs;

  // NOTE: every variable driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    lhs = acc;
    rhs = '0;
    case (state_e'(phase))
      AB: begin
        lhs = {2'b00, op_a};
        rhs = {2'b00, op_b};
      end
      C:       rhs = {2'b00, op_c};
      D:       rhs = {2'b00, op_d};
      default: ;
    endcase
  end

  // Operands are zero-extended by two bits, so four maximal values never wrap.
  assign sum      = lhs + rhs;
  assign acc_next = load ? sum : acc;

endmodule

// File: rtl/sum4_sched.sv
// Two-requester sequencer for the shared 4-operand accumulate datapath.
// Define SUM4_SCHED_RR_EN for round-robin arbitration; default is fixed priority.
module sum4_sched
  import sum4_pkg::*;
#(
  parameter int W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [4*W-1:0]       req0_ops,
  input  logic [4*W-1:0]       req1_ops,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W+1:0]         out_sum,
  output logic                 out_id,
  output logic                 busy
);

  state_e       state;
  state_e       state_next;
  logic [4*W-1:0] ops_q;
  logic         id_q;
  logic [W+1:0] acc;
  logic [W+1:0] acc_next;
  logic [W+1:0] dp_sum;
  logic         grant;
  logic         accept;
  logic         load;

`ifdef SUM4_SCHED_RR_EN
  logic last_q;

  // Reset value 1 makes requester 0 win the first tie.
  always_ff @(posedge clk) begin
    if (rst)         last_q <= 1'b1;
    else if (accept) last_q <= grant;
  end

  assign grant = (&req_valid) ? ~last_q : req_valid[1];
`else
  assign grant = ~req_valid[0];
`endif

  assign accept = (state == IDLE) && (|req_valid) && !rst;
  assign busy   = (state != IDLE);

  always_comb begin
    req_ready = '0;
    if (accept) req_ready = grant ? 2'b10 : 2'b01;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    unique case (state)
      IDLE: if (accept) state_next = AB;
      AB: begin
        load       = 1'b1;
        state_next = C;
      end
      C: begin
        load       = 1'b1;
        state_next = D;
      end
      D:       state_next = HOLD;
      HOLD:    if (out_valid && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  sum4_datapath #(.W(W)) u_datapath (
    .op_a     (ops_q[field_lsb(OP_A, W) +: W]),
    .op_b     (ops_q[field_lsb(OP_B, W) +: W]),
    .op_c     (ops_q[field_lsb(OP_C, W) +: W]),
    .op_d     (ops_q[field_lsb(OP_D, W) +: W]),
    .acc      (acc),
    .phase    (state),
    .load     (load),
    .sum      (dp_sum),
    .acc_next (acc_next)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      ops_q     <= '0;
      id_q      <= 1'b0;
      out_sum   <= '0;
      out_id    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      if (accept) begin
        ops_q <= grant ? req1_ops : req0_ops;
        id_q  <= grant;
      end
      if (state == D) begin
        out_sum   <= dp_sum;
        out_id    <= id_q;
        out_valid <= 1'b1;
      end else if (state == HOLD && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sum4_sched.sv
// Self-checking bench for sum4_sched: directed scenarios plus random traffic
// compared against a transaction-level latency model.
module tb_sum4_sched;

  localparam int W = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [4*W-1:0] req0_ops;
  logic [4*W-1:0] req1_ops;
  logic          out_valid;
  logic          out_ready;
  logic [W+1:0]  out_sum;
  logic          out_id;
  logic          busy;

  sum4_sched #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req0_ops  (req0_ops),
    .req1_ops  (req1_ops),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_id    (out_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;
  int grant1_cnt = 0;
  logic [1:0] seen_ready = 2'b00;
  int hs_ids[$];
  int hs_sums[$];
  int hs_cyc[$];

  // Reference model: idle flag, cycles left until the result, pending result.
  bit m_idle = 1'b1;
  int m_cnt  = 0;
  bit m_ov   = 1'b0;
  int m_sum  = 0;
  int m_id   = 0;
  int m_pend_sum = 0;
  int m_pend_id  = 0;
`ifdef SUM4_SCHED_RR_EN
  int m_last = 1;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] pk(input int a, input int b, input int c, input int d);
    logic [3:0] fa, fb, fc, fd;
    fa = 4'(a); fb = 4'(b); fc = 4'(c); fd = 4'(d);
    return {fd, fc, fb, fa};
  endfunction

  function automatic int op_sum(input logic [15:0] ops);
    int s = 0;
    for (int k = 0; k < 4; k++) s += int'(ops[k*W +: W]);
    return s;
  endfunction

  function automatic int pick();
    if (req_valid == 2'b11) begin
`ifdef SUM4_SCHED_RR_EN
      return (m_last == 1) ? 0 : 1;
`else
      return 0;
`endif
    end
    return req_valid[1] ? 1 : 0;
  endfunction

  function automatic logic [1:0] exp_ready();
    if (rst || !m_idle || req_valid == 2'b00) return 2'b00;
    return (pick() == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic model_edge();
    int g;
    if (rst) begin
      m_idle = 1'b1; m_cnt = 0; m_ov = 1'b0;
`ifdef SUM4_SCHED_RR_EN
      m_last = 1;
`endif
    end else if (m_idle) begin
      if (req_valid != 2'b00) begin
        g = pick();
`ifdef SUM4_SCHED_RR_EN
        m_last = g;
`endif
        m_idle = 1'b0;
        m_cnt  = 3;
        m_pend_sum = op_sum(g == 1 ? req1_ops : req0_ops);
        m_pend_id  = g;
      end
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_ov = 1'b1; m_sum = m_pend_sum; m_id = m_pend_id;
      end
    end else if (out_ready) begin
      m_ov = 1'b0; m_idle = 1'b1;
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    #1;
    check("req_ready", req_ready, exp_ready());
    seen_ready = req_ready;
    if (req_ready[1]) grant1_cnt++;
    if (!rst && out_valid && out_ready) begin
      hs_ids.push_back(int'(out_id));
      hs_sums.push_back(int'(out_sum));
      hs_cyc.push_back(cyc + 1);
    end
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    check("out_valid", out_valid, m_ov);
    check("busy", busy, !m_idle);
    if (m_ov) begin
      check("out_sum", out_sum, m_sum);
      check("out_id", out_id, m_id);
    end
  endtask

  task automatic send(input int r, input logic [15:0] ops, input int budget);
    bit got = 1'b0;
    if (r == 0) req0_ops = ops; else req1_ops = ops;
    req_valid[r] = 1'b1;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      if (seen_ready[r]) begin got = 1'b1; acc_cyc = cyc; end
    end
    req_valid[r] = 1'b0;
    check("grant_seen", got, 1);
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && !out_valid; i++) step();
    check("valid_seen", out_valid, 1);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && busy; i++) step();
    check("idle_reached", busy, 0);
  endtask

  initial begin
    int n;
    int n1;
    logic [15:0] ops;
    rst = 1'b1; req_valid = 2'b00; out_ready = 1'b1;
    req0_ops = '0; req1_ops = '0;
    @(negedge clk);
    step(); step();
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", out_sum, 0);
    check("rst_id", out_id, 0);

    // 1: single request
    send(0, pk(1, 2, 3, 4), 5);
    wait_valid(10);
    check("t1_latency", cyc - acc_cyc, 3);
    check("t1_sum", out_sum, 10);
    check("t1_id", out_id, 0);
    drain(10);
    check("t1_hs_sum", hs_sums[$], 10);

    // 2: maximum operands, no wrap
    send(1, pk(15, 15, 15, 15), 5);
    wait_valid(10);
    check("t2_sum", out_sum, 60);
    check("t2_id", out_id, 1);
    drain(10);

    // 3: both requesters valid with out_ready high
    n = hs_ids.size();
    req0_ops = 16'($urandom()); req1_ops = 16'($urandom());
    req_valid = 2'b11;
    for (int i = 0; i < 40 && hs_ids.size() < n + 4; i++) begin
      step();
      if (seen_ready[0]) req0_ops = 16'($urandom());
      if (seen_ready[1]) req1_ops = 16'($urandom());
    end
    req_valid = 2'b00;
    check("t3_count", hs_ids.size() - n, 4);
    if (hs_ids.size() >= n + 4) begin
      for (int k = 0; k < 4; k++) begin
`ifdef SUM4_SCHED_RR_EN
        check("t3_id", hs_ids[n + k], k % 2);
`else
        check("t3_id", hs_ids[n + k], 0);
`endif
        if (k > 0) check("t3_spacing", hs_cyc[n + k] - hs_cyc[n + k - 1], 5);
      end
    end
    drain(10);

    // 4: consumer stall
    out_ready = 1'b0;
    ops = 16'($urandom());
    send(0, ops, 5);
    wait_valid(10);
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t4_sum", out_sum, op_sum(ops));
      check("t4_id", out_id, 0);
      check("t4_valid", out_valid, 1);
      check("t4_ready", seen_ready, 0);
    end
    req_valid = 2'b00;
    out_ready = 1'b1;
    n = hs_ids.size();
    step();
    check("t4_hs", hs_ids.size() - n, 1);
    check("t4_busy", busy, 0);
    check("t4_valid_low", out_valid, 0);

    // 5: reset while in C
    n = hs_ids.size();
    send(0, pk(5, 6, 7, 1), 5);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_valid", out_valid, 0);
    check("t5_busy", busy, 0);
    send(0, pk(2, 2, 2, 2), 5);
    wait_valid(10);
    check("t5_latency", cyc - acc_cyc, 3);
    check("t5_sum", out_sum, 8);
    drain(10);
    check("t5_hs", hs_ids.size() - n, 1);

    // 6: requester 1 withdraws while busy
    n  = hs_ids.size();
    n1 = grant1_cnt;
    send(0, pk(3, 1, 4, 1), 5);
    req1_ops = 16'($urandom());
    req_valid[1] = 1'b1;
    step(); step();
    req_valid[1] = 1'b0;
    step();
    drain(10);
    step(); step(); step();
    check("t6_hs", hs_ids.size() - n, 1);
    check("t6_id", hs_ids[$], 0);
    check("t6_no_grant1", grant1_cnt - n1, 0);

    // 7: random traffic
    for (int t = 0; t < 400; t++) begin
      rst = ($urandom_range(0, 199) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && !seen_ready[i]) begin
          if ($urandom_range(0, 9) == 0) req_valid[i] = 1'b0;
        end else begin
          req_valid[i] = ($urandom_range(0, 2) == 0);
          if (i == 0) req0_ops = 16'($urandom());
          else        req1_ops = 16'($urandom());
        end
      end
      step();
    end
    rst = 1'b0; req_valid = 2'b00; out_ready = 1'b1;
    drain(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sum4_sched.md
# sum4_sched

Sequencing controller for the shared three-phase accumulate datapath: (a+b), then +c, then +d. Two requesters each present a set of four operands. The block arbitrates between them, launches one operation at a time through the accumulator, and returns the result with a requester tag over a valid/ready output. It sits between the operand producers and the consumer of the 4-operand sum, and replaces free-running, unsequenced use of the datapath.

## Interface
- W, 4, operand width in bits (W ≥ 1)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  2  bit i: requester i presents operands
- req_ready  out  2  bit i: requester i operands accepted this cycle
- req0_ops  in  4*W  requester 0 operands {d,c,b,a}; a = bits [W-1:0]
- req1_ops  in  4*W  requester 1 operands, same packing
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_sum  out  W+2  a+b+c+d
- out_id  out  1  requester that owned the result
- busy  out  1  high whenever state ≠ IDLE

Reset is synchronous and active-high: clock `clk`, reset `rst`; this polarity and synchronicity are fixed.

## Operation
- FSM states: IDLE → AB → C → D → HOLD → IDLE.
- IDLE with any req_valid:
  - arbiter picks grant g;
  - req_ready[g] = 1 combinationally for that cycle (the handshake);
  - operands of g and id g are latched;
  - next state is AB.
- IDLE with no req_valid: req_ready = 0 and the state stays IDLE.
- AB: acc ← a+b → C.
- C: acc ← acc+c → D.
- D: out_sum ← acc+d, out_valid ← 1, out_id ← g → HOLD.
- HOLD: out_sum and out_id hold stable.
  - out_valid & out_ready: out_valid ← 0 → IDLE.
  - Otherwise stay in HOLD.
- req_ready is 0 in every state except IDLE, and is 0 while rst is high.
- At most one req_ready bit is high in any cycle.
- Requesters hold req_valid and their operands until they see req_ready. Dropping valid early is legal and simply withdraws the request.
- Arithmetic: every operand is zero-extended to W+2 bits and acc is W+2 bits. The maximum sum is 4·(2^W−1) < 2^(W+2), so there is never any truncation or wrap.
- Reset, including mid-operation in any state:
  - state = IDLE;
  - acc = 0, out_sum = 0, out_id = 0;
  - out_valid = 0, busy = 0;
  - arbitration pointer = 1, so requester 0 wins the first tie;
  - any in-flight operation is discarded.
- A req_valid change during AB, C, D or HOLD has no effect until IDLE.

## Timing
- Acceptance edge E0 is the IDLE→AB edge, with req_ready high in the cycle before it.
- acc = a+b after E1 and acc = a+b+c after E2.
- out_valid = 1 after E3, so latency is 3 cycles from acceptance to out_valid.
- With out_ready held high, the HOLD→IDLE handshake happens at E4 and the next acceptance can occur at E5.
- Minimum initiation interval: 5 cycles.
- out_valid falls on the edge of the output handshake; the consumer never sees a duplicate result.

## Configuration
- `SUM4_SCHED_RR_EN` defined: round-robin arbitration.
  - When both requests are valid in IDLE, grant the requester not granted last.
  - The pointer updates only on an actual grant.
- Macro undefined: fixed priority.
  - Requester 0 always wins a tie.
  - The pointer register is not built.
- Single-request behaviour is identical in both builds.

## Structure
- Package `sum4_pkg`:
  - state enum (IDLE, AB, C, D, HOLD);
  - NUM_REQ = 2;
  - operand field offset constants for the {d,c,b,a} packing.
- Sub-module `sum4_datapath`:
  - inputs: operand registers, W+2-bit accumulator, phase select (AB/C/D) and load enable;
  - contains the single shared adder.
- `sum4_sched` holds the FSM, arbiter, handshake and output registers.

## Test plan
1. **Single request (W=4).** After reset, req0 only with a=1, b=2, c=3, d=4 and out_ready=1 → req_ready=2'b01 for one cycle, out_valid 3 cycles after acceptance, out_sum=10, out_id=0, busy low again after the handshake.
2. **Maximum operands.** req1 with a=b=c=d=15 → out_sum=60 (6'h3C), out_id=1, no wrap.
3. **Both requesters valid, out_ready=1.** With `SUM4_SCHED_RR_EN`, out_id sequence is 0,1,0,1 with 5-cycle spacing. Without the macro it is 0,0,0,0.
4. **Consumer stall.** out_ready low for 4 cycles in HOLD → out_sum and out_id stable, out_valid high, req_ready=0. Raising out_ready gives one handshake, then IDLE.
5. **Reset mid-operation.** rst high for one cycle while in state C → next cycle IDLE with out_valid=0 and acc=0. A following req0 with 2,2,2,2 gives out_sum=8 with normal latency.
6. **Early valid withdrawal.** req1 valid only while busy, dropped before IDLE → no grant to req1 and no spurious result.
